gen_fifo_arb: RTL

GEN_FIFO_ARB -- requirements
Module: gen_fifo_arb

---
 rtl/gen_fifo_arb.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/gen_fifo_arb.sv
// gen_fifo_arb
// Round-robin burst arbiter in front of N_REQ FIFO controllers. A grant
// lasts up to cfg_burst_len pops (0 counts as 1) and ends early when the
// granted FIFO runs empty. Every grant is followed by one IDLE cycle.
//
// Optional feature macro: GEN_FIFO_ARB_AF_PRIO_EN
//   defined   : almost-full eligible FIFOs are preferred at grant time
//               (still round-robin among them).
//   undefined : req_af is ignored, plain round-robin over eligible FIFOs.
module gen_fifo_arb #(
  parameter int N_REQ   = 4,
  parameter int BURST_W = 4,
  localparam int SEL_W  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_en,
  input  logic [BURST_W-1:0] cfg_burst_len,
  input  logic [N_REQ-1:0]   req_empty,
  input  logic [N_REQ-1:0]   req_af,
  input  logic               out_rdy,
  output logic [N_REQ-1:0]   pop,
  output logic [SEL_W-1:0]   sel,
  output logic               out_vld,
  output logic               sts_busy,
  output logic [BURST_W-1:0] sts_burst_cnt
);

  // FSM encoding
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  // Reset value of the last grant: FIFO 0 is searched first after reset
  localparam logic [SEL_W-1:0]   LAST_RST = SEL_W'(N_REQ - 1);
  localparam logic [SEL_W-1:0]   SEL_ZERO = {SEL_W{1'b0}};
  localparam logic [BURST_W-1:0] CNT_ZERO = {BURST_W{1'b0}};
  localparam logic [BURST_W-1:0] CNT_ONE  = BURST_W'(1);
  localparam logic [BURST_W-1:0] CNT_MAX  = {BURST_W{1'b1}};
  localparam logic [N_REQ-1:0]   POP_NONE = {N_REQ{1'b0}};

  // Round-robin pick: first set bit of mask searching upward from last+1,
  // wrapping at N_REQ-1. Returns last when the mask is empty (callers only
  // use the result when the mask is non-empty).
  function automatic logic [SEL_W-1:0] rr_pick(
    input logic [N_REQ-1:0] mask,
    input logic [SEL_W-1:0] last
  );
    logic [SEL_W-1:0] win;
    logic             found;
    int               idx;
    win   = last;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last) + k) % N_REQ;
      if (!found && mask[SEL_W'(idx)]) begin
        win   = SEL_W'(idx);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return win;
  endfunction

  // State registers
  logic [0:0]         r_state;
  logic [SEL_W-1:0]   r_sel;
  logic [SEL_W-1:0]   r_last;
  logic [BURST_W-1:0] r_cnt;

  // Next-state and datapath wires
  logic [0:0]         w_state_nxt;
  logic [SEL_W-1:0]   w_sel_nxt;
  logic [SEL_W-1:0]   w_last_nxt;
  logic [BURST_W-1:0] w_cnt_nxt;
  logic [N_REQ-1:0]   w_elig;
  logic               w_any_elig;
  logic [SEL_W-1:0]   w_winner;
  logic [BURST_W-1:0] w_lim_m1;
  logic               w_last_pop;
  logic               w_busy;
  logic               w_vld;
  logic               w_hs;
  logic [N_REQ-1:0]   w_pop;

  assign w_elig     = ~req_empty;
  assign w_any_elig = |w_elig;

`ifdef GEN_FIFO_ARB_AF_PRIO_EN
  logic [N_REQ-1:0] w_af_elig;
  assign w_af_elig = w_elig & req_af;
  assign w_winner  = (|w_af_elig) ? rr_pick(w_af_elig, r_last)
                                  : rr_pick(w_elig, r_last);
`else
  logic w_unused_af;
  assign w_unused_af = ^req_af;
  assign w_winner    = rr_pick(w_elig, r_last);
`endif

  // Burst limit minus one; a zero length behaves as a single-pop burst.
  // Compared with >= so a limit lowered mid-burst ends at the next pop.
  assign w_lim_m1   = (cfg_burst_len == CNT_ZERO) ? CNT_ZERO
                                                  : (cfg_burst_len - CNT_ONE);
  assign w_last_pop = (r_cnt >= w_lim_m1);

  // Same-cycle valid/pop for the granted FIFO; never pops an empty FIFO
  always_comb begin
    w_busy = 1'b0;
    w_vld  = 1'b0;
    w_hs   = 1'b0;
    w_pop  = POP_NONE;
    if (r_state == ST_BURST) begin
      w_busy = 1'b1;
      w_vld  = ~req_empty[r_sel];
      w_hs   = w_vld & out_rdy;
      if (w_hs) begin
        w_pop[r_sel] = 1'b1;
      end else begin
        w_pop = POP_NONE;
      end
    end else begin
      w_busy = 1'b0;
    end
  end

  // Next-state logic: grant from IDLE, count pops and close the burst
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (cfg_en && w_any_elig) begin
          w_state_nxt = ST_BURST;
          w_sel_nxt   = w_winner;
          w_cnt_nxt   = CNT_ZERO;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (req_empty[r_sel]) begin
          // Source ran dry: close the grant without popping
          w_state_nxt = ST_IDLE;
          w_last_nxt  = r_sel;
        end else if (w_hs) begin
          if (r_cnt != CNT_MAX) begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end else begin
            w_cnt_nxt = r_cnt;
          end
          if (w_last_pop) begin
            w_state_nxt = ST_IDLE;
            w_last_nxt  = r_sel;
          end else begin
            w_state_nxt = ST_BURST;
          end
        end else begin
          // Downstream stall: hold everything, no timeout
          w_state_nxt = ST_BURST;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State update with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sel   <= SEL_ZERO;
      r_last  <= LAST_RST;
      r_cnt   <= CNT_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign pop           = w_pop;
  assign sel           = r_sel;
  assign out_vld       = w_vld;
  assign sts_busy      = w_busy;
  assign sts_burst_cnt = r_cnt;

endmodule
